// File: rtl/hazard_pkg.sv
// ============================================================================
// Package     : hazard_pkg
// Description : Shared types and counter-width helper for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MDU  = 2'd2,
        LAT_RSVD = 2'd3
    } lat_class_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EX_DATA  = 2'd1,
        CAUSE_BR_DATA  = 2'd2,
        CAUSE_MDU_BUSY = 2'd3
    } stall_cause_e;

    // Bits needed to hold a countdown starting at max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sb_entry.sv
// ============================================================================
// Module      : hazard_sb_entry
// Description : Single pending-write down-counter; load wins over decrement,
//               decrement saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_sb_entry #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Counter-based ID-stage hazard detector (load-use, branch
//               operands, MDU latency and MDU busy). Optional stall-cycle
//               counter enabled by defining HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_EXTRA = 1,
    parameter int MDU_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_flush,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_lat_class,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [1:0]        stall_cause
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int c_max_load = ((LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT) + BR_EXTRA;
    localparam int c_cw       = cnt_width(c_max_load);

    localparam logic [c_cw-1:0] c_br_extra = c_cw'(BR_EXTRA);
    localparam logic [c_cw-1:0] c_val_alu  = c_cw'(BR_EXTRA);
    localparam logic [c_cw-1:0] c_val_load = c_cw'(LOAD_LAT + BR_EXTRA);
    localparam logic [c_cw-1:0] c_val_mdu  = c_cw'(MDU_LAT + BR_EXTRA);
    localparam logic [c_cw-1:0] c_mdu_busy = c_cw'(MDU_LAT);

    lat_class_e      w_class;
    logic            w_active;
    logic            w_issue;
    logic            w_wr_en;
    logic            w_mdu_issue;
    logic [c_cw-1:0] w_load_val;
    logic [c_cw-1:0] w_ctr [NUM_REGS];
    logic [c_cw-1:0] w_mdu_busy;
    logic [c_cw-1:0] w_rs_ctr;
    logic [c_cw-1:0] w_rt_ctr;
    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_data_hit;
    logic            w_mdu_hit;
    logic            w_stall;
    stall_cause_e    w_cause;

    assign w_class     = lat_class_e'(id_lat_class);
    assign w_active    = id_valid & ~id_flush;
    assign w_issue     = w_active & ~w_stall;
    assign w_wr_en     = w_issue & id_reg_write & (id_rd != '0);
    assign w_mdu_issue = w_issue & (w_class == LAT_MDU);

    always_comb begin
        w_load_val = c_val_alu;
        case (w_class)
            LAT_LOAD: w_load_val = c_val_load;
            LAT_MDU:  w_load_val = c_val_mdu;
            default:  w_load_val = c_val_alu;
        endcase
    end

    // Register 0 is hard-wired: its counter never leaves zero.
    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign w_ctr[r] = '0;
            end else begin : g_entry
                logic w_load;
                assign w_load = w_wr_en & (id_rd == REG_AW'(r));
                hazard_sb_entry #(
                    .CW (c_cw)
                ) u_entry (
                    .clk      (clk),
                    .rst      (rst),
                    .load     (w_load),
                    .load_val (w_load_val),
                    .count    (w_ctr[r])
                );
            end
        end
    endgenerate

    hazard_sb_entry #(
        .CW (c_cw)
    ) u_mdu_busy (
        .clk      (clk),
        .rst      (rst),
        .load     (w_mdu_issue),
        .load_val (c_mdu_busy),
        .count    (w_mdu_busy)
    );

    // Branches read operands a stage earlier, so any outstanding count blocks them.
    assign w_rs_ctr = w_ctr[id_rs];
    assign w_rt_ctr = w_ctr[id_rt];
    assign w_rs_hit = id_use_rs & (id_rs != '0) &
                      (id_is_branch ? (w_rs_ctr != '0) : (w_rs_ctr > c_br_extra));
    assign w_rt_hit = id_use_rt & (id_rt != '0) &
                      (id_is_branch ? (w_rt_ctr != '0) : (w_rt_ctr > c_br_extra));
    assign w_data_hit = w_rs_hit | w_rt_hit;
    assign w_mdu_hit  = (w_class == LAT_MDU) & (w_mdu_busy != '0);
    assign w_stall    = w_active & (w_data_hit | w_mdu_hit);

    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_active) begin
            if (w_data_hit) begin
                w_cause = id_is_branch ? CAUSE_BR_DATA : CAUSE_EX_DATA;
            end else if (w_mdu_hit) begin
                w_cause = CAUSE_MDU_BUSY;
            end
        end
    end

    assign stall       = w_stall;
    assign pc_write    = ~w_stall;
    assign if_id_write = ~w_stall;
    assign stall_cause = w_cause;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= '0;
        end else if (w_stall && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_cnt;
`else
    // No stall-cycle counter in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scoreboard bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam logic [1:0] C_ALU  = 2'd0;
    localparam logic [1:0] C_LOAD = 2'd1;
    localparam logic [1:0] C_MDU  = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_flush, id_use_rs, id_use_rt, id_is_branch, id_reg_write;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] id_lat_class;
    logic       stall, pc_write, if_id_write;
    logic [1:0] stall_cause;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_flush     (id_flush),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_reg_write (id_reg_write),
        .id_rd        (id_rd),
        .id_lat_class (id_lat_class),
        .stall        (stall),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .stall_cause  (stall_cause)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic        es;
        logic [1:0]  ec;
        int unsigned perf;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_perf = 0;
    int          cyc_no = 0;

    task automatic compare(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc_no, act, req);
        end
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) begin
                compare("stall", stall, e.es);
                compare("pc_write", pc_write, !e.es);
                compare("if_id_write", if_id_write, !e.es);
                compare("stall_cause", stall_cause, e.ec);
`ifdef HAZARD_PERF_EN
                compare("perf_stall_cnt", perf_stall_cnt, e.perf);
`endif
            end
        end
    end

    task automatic set_id(input logic v, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic br, input logic wr,
                          input logic [4:0] rd, input logic [1:0] cls);
        id_valid = v; id_flush = fl; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_is_branch = br;
        id_reg_write = wr; id_rd = rd; id_lat_class = cls;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, C_ALU);
    endtask

    task automatic prod(input logic [4:0] rd, input logic [1:0] cls);
        set_id(1, 0, 0, 0, 0, 0, 0, 1, rd, cls);
    endtask

    task automatic step(input bit chk, input logic es, input logic [1:0] ec);
        exp_t e;
        e.chk = chk; e.es = es; e.ec = ec; e.perf = exp_perf;
        sb.push_back(e);
        if (rst) exp_perf = 0;
        else if (es) exp_perf++;
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic cyc(input logic es, input logic [1:0] ec, input int n = 1);
        for (int i = 0; i < n; i++) step(1'b1, es, ec);
    endtask

    initial begin
        nop();
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        cyc(0, 0);

        // Load-use: one EX-data bubble
        prod(3, C_LOAD);                        cyc(0, 0);
        set_id(1, 0, 3, 5, 1, 1, 0, 1, 4, C_ALU); cyc(1, 1); cyc(0, 0);
        nop();                                  cyc(0, 0, 2);

        // ALU -> branch: one, load -> branch: two
        prod(7, C_ALU);                         cyc(0, 0);
        set_id(1, 0, 7, 0, 1, 1, 1, 0, 0, C_ALU); cyc(1, 2); cyc(0, 0);
        nop();                                  cyc(0, 0);
        prod(7, C_LOAD);                        cyc(0, 0);
        set_id(1, 0, 7, 0, 1, 1, 1, 0, 0, C_ALU); cyc(1, 2, 2); cyc(0, 0);
        nop();                                  cyc(0, 0, 2);

        // MDU busy against an independent MDU op
        prod(9, C_MDU);                         cyc(0, 0);
        set_id(1, 0, 11, 12, 1, 1, 0, 1, 10, C_MDU); cyc(1, 3, 4); cyc(0, 0);
        nop();                                  cyc(0, 0, 6);

        // Dependent ALU use of an MDU result
        prod(9, C_MDU);                         cyc(0, 0);
        set_id(1, 0, 9, 0, 1, 0, 0, 1, 4, C_ALU); cyc(1, 1, 4); cyc(0, 0);
        nop();                                  cyc(0, 0, 2);

        // r0 is never tracked
        prod(0, C_LOAD);                        cyc(0, 0);
        set_id(1, 0, 0, 0, 1, 1, 1, 0, 0, C_ALU); cyc(0, 0);

        // rs == rt: single bubble
        prod(3, C_LOAD);                        cyc(0, 0);
        set_id(1, 0, 3, 3, 1, 1, 0, 1, 8, C_ALU); cyc(1, 1); cyc(0, 0);
        nop();                                  cyc(0, 0, 2);

        // Flush masks stall and leaves r6 untouched
        prod(5, C_LOAD);                        cyc(0, 0);
        set_id(1, 1, 5, 5, 1, 1, 0, 1, 6, C_LOAD); cyc(0, 0);
        set_id(1, 0, 6, 0, 1, 0, 1, 0, 0, C_ALU);  cyc(0, 0);
        nop();                                  cyc(0, 0, 2);

        // Reset in the middle of a two-cycle branch stall
        prod(7, C_LOAD);                        cyc(0, 0);
        set_id(1, 0, 7, 0, 1, 1, 1, 0, 0, C_ALU); cyc(1, 2);
        rst = 1'b1;                             step(1'b0, 1'b1, 2'd2);
        rst = 1'b0;                             cyc(0, 0);
        nop();                                  cyc(0, 0, 2);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
